// File: rtl/sprite_locator_pkg.sv
// Shared definitions for the sprite locator slice.
//   chan_t  : one 8-bit color channel
//   SUM_W   : coordinate accumulator / dividend width (sized for 1024x768)
//   CNT_W   : matching-pixel counter / divisor width
//   HC_W/VC_W : hcount / vcount widths of the video stream
//   state_t : control FSM encoding
package sprite_locator_pkg;
  localparam int SUM_W = 30;
  localparam int CNT_W = 20;
  localparam int HC_W  = 11;
  localparam int VC_W  = 10;

  typedef logic [7:0] chan_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIV_X   = 2'd1,
    DIV_Y   = 2'd2,
    PUBLISH = 2'd3
  } state_t;
endpackage

// File: rtl/sprite_locator_if.sv
// Video stream in / sprite position out bundle for sprite_locator.
//   hcount, vcount, display, pixel : pixel stream shared with the sprite renderers
//   x, y, found, valid, busy       : per-frame locate result and divider status
// slave  : the locator (consumes the stream, drives the result)
// master : the stream source / result consumer
interface sprite_locator_if;
  import sprite_locator_pkg::*;

  logic [HC_W-1:0] hcount;
  logic [VC_W-1:0] vcount;
  logic            display;
  logic [23:0]     pixel;
  logic [HC_W-1:0] x;
  logic [VC_W-1:0] y;
  logic            found;
  logic            valid;
  logic            busy;

  modport slave  (input  hcount, vcount, display, pixel,
                  output x, y, found, valid, busy);
  modport master (output hcount, vcount, display, pixel,
                  input  x, y, found, valid, busy);
endinterface

// File: rtl/sprite_locator_seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, truncating.
//   clock, reset_n : pixel clock, async active-low reset
//   start          : load dividend/divisor; accepted even in the done cycle
//   dividend       : DATA_W-bit numerator
//   divisor        : DIV_W-bit denominator (caller guarantees non-zero)
//   done           : high during the last iteration cycle, DATA_W cycles after start
//   quotient       : valid while done is high
module sprite_locator_seq_divider
  import sprite_locator_pkg::*;
#(
  parameter int DATA_W = SUM_W,
  parameter int DIV_W  = CNT_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DIV_W-1:0]  divisor,
  output logic              done,
  output logic [DATA_W-1:0] quotient
);
  localparam int STEP_W = $clog2(DATA_W);

  logic              running;
  logic [STEP_W-1:0] step;
  // quo shifts dividend bits out of the top and quotient bits in at the bottom
  logic [DATA_W-1:0] quo;
  logic [DIV_W-1:0]  rem;
  logic [DIV_W-1:0]  dsr;
  logic [DIV_W:0]    rem_sh;
  logic [DIV_W:0]    trial;
  logic              q_bit;
  logic [DIV_W-1:0]  rem_next;

  always_comb begin
    rem_sh   = {rem, quo[DATA_W-1]};
    trial    = rem_sh - {1'b0, dsr};
    q_bit    = (rem_sh >= {1'b0, dsr});
    // Either branch is below the divisor, so it always fits DIV_W bits
    rem_next = DIV_W'(q_bit ? trial : rem_sh);
    // Final quotient is presented combinationally so the caller can capture it
    // and restart the divider on the same edge
    quotient = {quo[DATA_W-2:0], q_bit};
    done     = running && (step == STEP_W'(DATA_W - 1));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      running <= 1'b0;
      step    <= '0;
    end else if (start) begin
      running <= 1'b1;
      step    <= '0;
    end else if (running) begin
      if (done) running <= 1'b0;
      else      step    <= step + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (start) begin
      quo <= dividend;
      rem <= '0;
      dsr <= divisor;
    end else if (running) begin
      quo <= quotient;
      rem <= rem_next;
    end
  end
endmodule

// File: rtl/sprite_locator.sv
// Locates a colored sprite in the pixel stream and reports its top-left corner.
// Pixels within TOLERANCE of TARGET_COLOR on every channel are accumulated;
// at end of active video the sums are divided by the count to get the
// centroid, RADIUS is removed, and one result is published per frame.
//   clock   : pixel clock
//   reset_n : asynchronous active-low reset
//   vid     : stream in (hcount/vcount/display/pixel), result out
//             (x/y/found, one-cycle valid, busy while dividing/publishing)
module sprite_locator
  import sprite_locator_pkg::*;
#(
  parameter logic [23:0]      TARGET_COLOR = 24'hFF_00_FF,
  parameter logic [7:0]       TOLERANCE    = 8'd24,
  parameter int               RADIUS       = 16,
  parameter logic [CNT_W-1:0] MIN_COUNT    = 20'd64,
  parameter int               V_ACTIVE     = 768
) (
  input  logic             clock,
  input  logic             reset_n,
  sprite_locator_if.slave  vid
);
  function automatic logic chan_ok(chan_t a, chan_t b);
    chan_t d;
    d = (a > b) ? (a - b) : (b - a);
    return d <= TOLERANCE;
  endfunction

  // Remove RADIUS from a centroid coordinate, clamped to [0, limit]
  function automatic logic [SUM_W-1:0] sat_corner(logic [SUM_W-1:0] c,
                                                  logic [SUM_W-1:0] limit);
    logic [SUM_W-1:0] d;
    if (c < SUM_W'(RADIUS)) return '0;
    d = c - SUM_W'(RADIUS);
    return (d > limit) ? limit : d;
  endfunction

  logic            match_p1;
  logic [HC_W-1:0] hcount_p1;
  logic [VC_W-1:0] vcount_p1;
  logic [VC_W-1:0] vcount_p2;
  logic            frame_end;

  // ---- stage 1: color match, coordinates delayed alongside ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      match_p1  <= 1'b0;
      vcount_p1 <= '0;
      vcount_p2 <= '0;
    end else begin
      match_p1  <= vid.display
                   && chan_ok(vid.pixel[23:16], TARGET_COLOR[23:16])
                   && chan_ok(vid.pixel[15:8],  TARGET_COLOR[15:8])
                   && chan_ok(vid.pixel[7:0],   TARGET_COLOR[7:0]);
      vcount_p1 <= vid.vcount;
      vcount_p2 <= vcount_p1;
    end
  end

  always_ff @(posedge clock) hcount_p1 <= vid.hcount;

  assign frame_end = (vcount_p1 == VC_W'(V_ACTIVE)) && (vcount_p2 != VC_W'(V_ACTIVE));

  // ---- stage 2: accumulate matches, clear on frame end ----
  logic [SUM_W-1:0] sum_x, sum_y, snap_y;
  logic [CNT_W-1:0] count, snap_cnt;
  logic             count_ok;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sum_x <= '0;
      sum_y <= '0;
      count <= '0;
    end else if (frame_end) begin
      sum_x <= '0;
      sum_y <= '0;
      count <= '0;
    end else if (match_p1) begin
      sum_x <= sum_x + SUM_W'(hcount_p1);
      sum_y <= sum_y + SUM_W'(vcount_p1);
      count <= count + 1'b1;
    end
  end

  assign count_ok = (count >= MIN_COUNT) && (count != '0);

  // ---- divide / publish control ----
  state_t           state, state_nx;
  logic             div_start, div_done, cx_load, cy_load, pub_found;
  logic [SUM_W-1:0] div_dividend, div_quot, cx, cy;
  logic [CNT_W-1:0] div_divisor;
  logic             take_frame;

  // A frame end seen outside IDLE is dropped; only IDLE takes a snapshot
  assign take_frame = (state == IDLE) && frame_end;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    div_start    = 1'b0;
    div_dividend = sum_x;
    div_divisor  = count;
    cx_load      = 1'b0;
    cy_load      = 1'b0;
    case (state)
      IDLE: begin
        if (frame_end) begin
          if (count_ok) begin
            div_start = 1'b1;
            state_nx  = DIV_X;
          end else begin
            state_nx  = PUBLISH;
          end
        end
      end
      DIV_X: begin
        if (div_done) begin
          cx_load      = 1'b1;
          div_start    = 1'b1;
          div_dividend = snap_y;
          div_divisor  = snap_cnt;
          state_nx     = DIV_Y;
        end
      end
      DIV_Y: begin
        if (div_done) begin
          cy_load  = 1'b1;
          state_nx = PUBLISH;
        end
      end
      PUBLISH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  sprite_locator_seq_divider #(.DATA_W(SUM_W), .DIV_W(CNT_W)) seq_divider (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .done     (div_done),
    .quotient (div_quot)
  );

  always_ff @(posedge clock) begin
    if (take_frame) begin
      snap_y   <= sum_y;
      snap_cnt <= count;
    end
    if (cx_load) cx <= div_quot;
    if (cy_load) cy <= div_quot;
  end

  logic [HC_W-1:0] x_q;
  logic [VC_W-1:0] y_q;
  logic            found_q, valid_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pub_found <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      found_q   <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      if (take_frame)   pub_found <= 1'b0;
      else if (cy_load) pub_found <= 1'b1;
      valid_q <= (state == PUBLISH);
      if (state == PUBLISH) begin
        found_q <= pub_found;
        // A miss keeps the last known position
        if (pub_found) begin
          x_q <= HC_W'(sat_corner(cx, SUM_W'((1 << HC_W) - 1)));
          y_q <= VC_W'(sat_corner(cy, SUM_W'((1 << VC_W) - 1)));
        end
      end
    end
  end

  assign vid.x     = x_q;
  assign vid.y     = y_q;
  assign vid.found = found_q;
  assign vid.valid = valid_q;
  assign vid.busy  = (state != IDLE);
endmodule

// File: tb/tb_sprite_locator.sv
// Scoreboard bench for sprite_locator: stimulus pushes the expected result of
// each frame with the cycle it is due; a monitor pops on every valid pulse.
module tb_sprite_locator;
  localparam logic [23:0] TARGET = 24'hFF00FF;
  localparam logic [23:0] OFF25  = 24'hE600FF;
  localparam logic [23:0] OFF24  = 24'hE700FF;

  logic clock = 1'b0;
  logic reset_n;
  sprite_locator_if vif();

  sprite_locator dut (
    .clock   (clock),
    .reset_n (reset_n),
    .vid     (vif)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int x;
    int y;
    int found;
    int due;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  // Monitor: every valid pulse must match the oldest outstanding expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (vif.valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid at cycle %0d: actual=1 required=0", cyc);
        end else begin
          e = sb.pop_front();
          check("x", int'(vif.x), e.x);
          check("y", int'(vif.y), e.y);
          check("found", int'(vif.found), e.found);
          check("valid_cycle", cyc, e.due);
          check("busy_at_valid", int'(vif.busy), 0);
        end
      end
    end
  end

  task automatic drive(input int h, input int v, input logic d, input logic [23:0] p);
    @(negedge clock);
    vif.hcount  = 11'(h);
    vif.vcount  = 10'(v);
    vif.display = d;
    vif.pixel   = p;
  endtask

  // Radius-16 disc centered at (cx,cy) on black, clipped to the frame origin
  task automatic send_disc(input int cx, input int cy, input logic [23:0] col);
    for (int v = cy - 16; v <= cy + 16; v++)
      for (int h = cx - 16; h <= cx + 16; h++)
        if (h >= 0 && v >= 0)
          drive(h, v, 1'b1,
                ((h - cx) * (h - cx) + (v - cy) * (v - cy) <= 256) ? col : 24'h0);
  endtask

  task automatic send_line(input int v, input int h0, input int n, input logic d);
    for (int h = h0; h < h0 + n; h++) drive(h, v, d, TARGET);
  endtask

  task automatic end_frame(input int ex, input int ey, input int ef, input int lat);
    exp_t e;
    int n;
    drive(0, 768, 1'b0, 24'h0);
    n = cyc;
    e.x = ex; e.y = ey; e.found = ef; e.due = n + lat;
    sb.push_back(e);
    drive(0, 768, 1'b0, 24'h0);
    drive(0, 768, 1'b0, 24'h0);
    check("busy_at_N+2", int'(vif.busy), 1);
    for (int i = 0; i < 150 && sb.size() != 0; i++) drive(0, 0, 1'b0, 24'h0);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL result_timeout: actual=no_valid required=valid_by_cycle_%0d", n + lat);
      sb.delete();
    end
    drive(0, 0, 1'b0, 24'h0);
  endtask

  initial begin
    int n;
    reset_n     = 1'b0;
    vif.hcount  = '0;
    vif.vcount  = '0;
    vif.display = 1'b0;
    vif.pixel   = '0;
    repeat (3) @(negedge clock);
    check("rst_x", int'(vif.x), 0);
    check("rst_y", int'(vif.y), 0);
    check("rst_found", int'(vif.found), 0);
    check("rst_valid", int'(vif.valid), 0);
    check("rst_busy", int'(vif.busy), 0);
    reset_n = 1'b1;
    drive(0, 0, 1'b0, 24'h0);

    send_disc(116, 216, TARGET);  end_frame(100, 200, 1, 63);
    send_disc(116, 216, 24'h0);   end_frame(100, 200, 0, 3);
    send_disc(10, 5, TARGET);     end_frame(0, 0, 1, 63);
    send_disc(316, 416, OFF25);   end_frame(0, 0, 0, 3);
    send_disc(316, 416, OFF24);   end_frame(300, 400, 1, 63);
    send_line(50, 200, 64, 1'b0); end_frame(300, 400, 0, 3);
    send_line(50, 200, 63, 1'b1); end_frame(300, 400, 0, 3);
    // mean column 231.5 truncates to 231
    send_line(50, 200, 64, 1'b1); end_frame(215, 34, 1, 63);

    // Reset in the middle of DIV_X: outputs clear at once, no result appears
    send_disc(116, 216, TARGET);
    drive(0, 768, 1'b0, 24'h0);
    n = cyc;
    for (int i = 0; i < 40 && cyc < n + 20; i++) drive(0, 768, 1'b0, 24'h0);
    check("busy_mid_div", int'(vif.busy), 1);
    reset_n = 1'b0;
    #1;
    check("abort_x", int'(vif.x), 0);
    check("abort_y", int'(vif.y), 0);
    check("abort_found", int'(vif.found), 0);
    check("abort_valid", int'(vif.valid), 0);
    check("abort_busy", int'(vif.busy), 0);
    repeat (3) drive(0, 0, 1'b0, 24'h0);
    reset_n = 1'b1;
    repeat (80) drive(0, 0, 1'b0, 24'h0);

    send_disc(116, 216, TARGET);  end_frame(100, 200, 1, 63);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
